word_serializer: RTL and testbench

Generalised parallel-to-serial converter: accepts a `width`-bit word and emits it as `width/out_width` chunks of `out_width` bits. Bit order is selectable per word (LSB-first or MSB-first), and the serial side has full valid/ready backpressure. The first chunk is presented in the accept cycle, and successive words stream without gap cycles. It sits between a word-oriented producer and a narrow link or shift interface.

---
 rtl/word_serializer_pkg.sv | 35 +++
 rtl/word_serializer_beat_counter.sv | 30 +++
 rtl/word_serializer.sv | 104 ++++++++++
 tb/tb_word_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding,
// beat-count arithmetic and the chunk selector used for both bit orders.
package word_serializer_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } ser_state_e;

    function automatic int beats(input int width, input int out_width);
        return (out_width > 0) ? width / out_width : 0;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns chunk idx right-aligned in a MAX_WIDTH vector; callers truncate to out_width.
    function automatic logic [MAX_WIDTH-1:0] chunk_sel(
        input logic [MAX_WIDTH-1:0] word,
        input int                   idx,
        input logic                 msb_first,
        input int                   width,
        input int                   out_width
    );
        logic [MAX_WIDTH-1:0] mask;
        int                   pos;
        mask = ~({MAX_WIDTH{1'b1}} << out_width);
        pos  = msb_first ? width - (idx + 1) * out_width : idx * out_width;
        return (word >> pos) & mask;
    endfunction

endpackage

// File: rtl/word_serializer_beat_counter.sv
// Beat index for the word in flight: loads 1 on accept, steps on each
// serial transfer and clears after the final chunk.
module beat_counter
    import word_serializer_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         last
);

    assign last = (idx == W'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (load) begin
            idx <= W'(1);
        end else if (inc) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: emits a width-bit word as width/out_width
// chunks, chunk 0 combinationally in the accept cycle, with valid/ready backpressure.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int width     = 8,
    parameter int out_width = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 parallel_valid,
    output logic                 parallel_ready,
    input  logic [width-1:0]     parallel_data,
    input  logic                 msb_first,
    output logic                 busy,
    output logic                 serial_valid,
    input  logic                 serial_ready,
    output logic [out_width-1:0] serial_data,
    output logic                 serial_last
);

    localparam int N  = beats(width, out_width);
    localparam int IW = idx_width(N);

    if (out_width < 1 || (width % out_width) != 0) begin : g_bad_width
        $error("word_serializer: width %0d is not a multiple of out_width %0d", width, out_width);
    end
    if (N < 2) begin : g_bad_beats
        $error("word_serializer: width/out_width must be at least 2 (got %0d)", N);
    end
    if (width > MAX_WIDTH) begin : g_too_wide
        $error("word_serializer: width %0d exceeds supported maximum %0d", width, MAX_WIDTH);
    end

    ser_state_e        state;
    ser_state_e        state_next;
    logic [width-1:0]  word_q;
    logic              order_q;
    logic [IW-1:0]     idx;
    logic              idx_last;
    logic              accept;
    logic              advance;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next     = state;
        busy           = 1'b0;
        serial_last    = 1'b0;
        serial_valid   = parallel_valid;
        parallel_ready = serial_ready;
        serial_data    = parallel_valid
                       ? out_width'(chunk_sel(MAX_WIDTH'(parallel_data), 0, msb_first, width, out_width))
                       : '0;

        case (state)
            S_IDLE: begin
                if (parallel_valid && serial_ready) state_next = S_BUSY;
            end
            S_BUSY: begin
                // Reset is synchronous, so the reset cycle is forced onto the idle equations.
                if (!rst) begin
                    busy           = 1'b1;
                    serial_valid   = 1'b1;
                    parallel_ready = 1'b0;
                    serial_last    = idx_last;
                    serial_data    = out_width'(chunk_sel(MAX_WIDTH'(word_q), int'(idx),
                                                          order_q, width, out_width));
                    if (serial_ready && idx_last) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept  = parallel_valid && parallel_ready;
    assign advance = busy && serial_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            word_q  <= '0;
            order_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                word_q  <= parallel_data;
                order_q <= msb_first;
            end
        end
    end

    beat_counter #(
        .N (N),
        .W (IW)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .inc  (advance),
        .idx  (idx),
        .last (idx_last)
    );

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three instances (out_width 1, 2, 4) checked every
// cycle against a queue-of-chunks model, plus literal checks of logged transfers.
module tb_word_serializer;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       pv[3];
    logic       ms[3];
    logic       sr[3];
    logic [7:0] pd[3];
    logic       pr[3];
    logic       bs[3];
    logic       sv[3];
    logic       sl[3];
    logic [0:0] sd1;
    logic [1:0] sd2;
    logic [3:0] sd4;
    logic [3:0] sd[3];

    int n_cmp = 0;
    int n_bad = 0;

    iq_t mq[3];
    iq_t tr_d[3];
    iq_t tr_l[3];
    iq_t tr_b[3];
    iq_t cy_pr[3];
    iq_t cy_b[3];
    iq_t cy_v[3];
    iq_t cy_d[3];

    assign sd[0] = {3'b000, sd1};
    assign sd[1] = {2'b00, sd2};
    assign sd[2] = sd4;

    always #5 clk = ~clk;

    word_serializer #(.width(8), .out_width(1)) u_ow1 (
        .clk(clk), .rst(rst), .parallel_valid(pv[0]), .parallel_ready(pr[0]),
        .parallel_data(pd[0]), .msb_first(ms[0]), .busy(bs[0]), .serial_valid(sv[0]),
        .serial_ready(sr[0]), .serial_data(sd1), .serial_last(sl[0]));

    word_serializer #(.width(8), .out_width(2)) u_ow2 (
        .clk(clk), .rst(rst), .parallel_valid(pv[1]), .parallel_ready(pr[1]),
        .parallel_data(pd[1]), .msb_first(ms[1]), .busy(bs[1]), .serial_valid(sv[1]),
        .serial_ready(sr[1]), .serial_data(sd2), .serial_last(sl[1]));

    word_serializer #(.width(8), .out_width(4)) u_ow4 (
        .clk(clk), .rst(rst), .parallel_valid(pv[2]), .parallel_ready(pr[2]),
        .parallel_data(pd[2]), .msb_first(ms[2]), .busy(bs[2]), .serial_valid(sv[2]),
        .serial_ready(sr[2]), .serial_data(sd4), .serial_last(sl[2]));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    function automatic string nm(input int k, input string s);
        return $sformatf("u%0d %s t=%0t", k, s, $time);
    endfunction

    function automatic int ow_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    // Chunks in transmit order: peel from the LSB end, reversing the list for MSB-first.
    function automatic iq_t chunks_of(input logic [7:0] w, input logic msb, input int ow);
        iq_t c;
        int  v;
        int  mask;
        v    = int'(w);
        mask = (1 << ow) - 1;
        for (int i = 0; i < 8 / ow; i++) begin
            if (msb) c.push_front(v & mask);
            else     c.push_back(v & mask);
            v = v >> ow;
        end
        return c;
    endfunction

    function automatic logic [31:0] pack(input iq_t q, input int cnt, input int ow);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < cnt; i++) p = (p << ow) | 32'((i < q.size()) ? q[i] : 0);
        return p;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            iq_t  ch;
            logic busy_m;
            logic e_valid;
            logic e_last;
            logic e_pr;
            int   e_data;
            ch     = chunks_of(pd[k], ms[k], ow_of(k));
            busy_m = (mq[k].size() != 0) && !rst;
            if (busy_m) begin
                e_valid = 1'b1;
                e_data  = mq[k][0];
                e_last  = (mq[k].size() == 1);
                e_pr    = 1'b0;
            end else begin
                e_valid = pv[k];
                e_data  = pv[k] ? ch[0] : 0;
                e_last  = 1'b0;
                e_pr    = sr[k];
            end
            check(nm(k, "busy"),           32'(bs[k]), 32'(busy_m));
            check(nm(k, "serial_valid"),   32'(sv[k]), 32'(e_valid));
            check(nm(k, "serial_data"),    32'(sd[k]), 32'(e_data));
            check(nm(k, "serial_last"),    32'(sl[k]), 32'(e_last));
            check(nm(k, "parallel_ready"), 32'(pr[k]), 32'(e_pr));

            cy_pr[k].push_back(int'(pr[k]));
            cy_b[k].push_back(int'(bs[k]));
            cy_v[k].push_back(int'(sv[k]));
            cy_d[k].push_back(int'(sd[k]));
            if (sv[k] && sr[k]) begin
                tr_d[k].push_back(int'(sd[k]));
                tr_l[k].push_back(int'(sl[k]));
                tr_b[k].push_back(int'(bs[k]));
            end

            if (rst) begin
                mq[k].delete();
            end else if (busy_m) begin
                if (sr[k]) void'(mq[k].pop_front());
            end else if (pv[k] && sr[k]) begin
                for (int i = 1; i < ch.size(); i++) mq[k].push_back(ch[i]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs(input int k);
        tr_d[k].delete();
        tr_l[k].delete();
        tr_b[k].delete();
        cy_pr[k].delete();
        cy_b[k].delete();
        cy_v[k].delete();
        cy_d[k].delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iq_t pin;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            ms[k] = 1'b0;
            sr[k] = 1'b1;
            pd[k] = 8'h00;
        end

        pin = chunks_of(8'hB4, 1'b1, 2);
        check("model B4 msb ow2 chunk0", 32'(pin[0]), 32'd2);
        check("model B4 msb ow2 chunk1", 32'(pin[1]), 32'd3);
        pin = chunks_of(8'h0F, 1'b0, 4);
        check("model 0F lsb ow4 chunk1", 32'(pin[1]), 32'd0);

        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check(nm(k, "reset busy"),  32'(bs[k]), 32'd0);
            check(nm(k, "reset valid"), 32'(sv[k]), 32'd0);
            check(nm(k, "reset ready"), 32'(pr[k]), 32'd1);
        end
        cyc(1);

        // 0xA5, 1-bit chunks, LSB-first
        clear_logs(0);
        pv[0] = 1'b1; pd[0] = 8'hA5; ms[0] = 1'b0;
        cyc(1);
        pv[0] = 1'b0;
        cyc(9);
        check("A5 transfers", 32'(tr_d[0].size()), 32'd8);
        check("A5 data",      pack(tr_d[0], 8, 1), 32'hA5);
        check("A5 last",      pack(tr_l[0], 8, 1), 32'h01);
        check("A5 busy",      pack(cy_b[0], 9, 1), 32'h0FE);

        // 0xB4, 2-bit chunks, MSB-first, order toggled mid-word
        clear_logs(1);
        pv[1] = 1'b1; pd[1] = 8'hB4; ms[1] = 1'b1;
        cyc(1);
        pv[1] = 1'b0; ms[1] = 1'b0;
        cyc(1);
        ms[1] = 1'b1;
        cyc(1);
        ms[1] = 1'b0;
        cyc(3);
        check("B4 transfers", 32'(tr_d[1].size()), 32'd4);
        check("B4 data",      pack(tr_d[1], 4, 2), 32'hB4);
        check("B4 last",      pack(tr_l[1], 4, 1), 32'h1);

        // 0x0F then 0xF0 back to back, 4-bit chunks
        clear_logs(2);
        pv[2] = 1'b1; pd[2] = 8'h0F; ms[2] = 1'b0;
        cyc(1);
        pd[2] = 8'hF0;
        cyc(2);
        pv[2] = 1'b0;
        cyc(3);
        check("0F/F0 transfers", 32'(tr_d[2].size()), 32'd4);
        check("0F/F0 data",      pack(tr_d[2], 4, 4), 32'hF00F);
        check("0F/F0 last",      pack(tr_l[2], 4, 1), 32'h5);
        check("0F/F0 ready",     pack(cy_pr[2], 4, 1), 32'hA);

        // 0x3C with a 3-cycle stall after chunk 2
        clear_logs(0);
        pv[0] = 1'b1; pd[0] = 8'h3C; ms[0] = 1'b0;
        cyc(1);
        pv[0] = 1'b0;
        cyc(2);
        sr[0] = 1'b0;
        cyc(3);
        sr[0] = 1'b1;
        cyc(6);
        check("3C transfers",   32'(tr_d[0].size()), 32'd8);
        check("3C data",        pack(tr_d[0], 8, 1), 32'h3C);
        check("3C last",        pack(tr_l[0], 8, 1), 32'h01);
        check("3C cycle data",  pack(cy_d[0], 11, 1), 32'h1FC);
        check("3C cycle valid", pack(cy_v[0], 11, 1), 32'h7FF);

        // Idle stall: word offered while the consumer is not ready
        clear_logs(1);
        pv[1] = 1'b1; pd[1] = 8'h5A; ms[1] = 1'b0; sr[1] = 1'b0;
        cyc(4);
        sr[1] = 1'b1;
        cyc(1);
        pv[1] = 1'b0;
        cyc(4);
        check("idle stall ready", pack(cy_pr[1], 8, 1), 32'h08);
        check("idle stall busy",  pack(cy_b[1], 8, 1), 32'h07);
        check("idle stall valid", pack(cy_v[1], 4, 1), 32'hF);
        check("idle stall data",  pack(tr_d[1], 4, 2), 32'hA5);

        // Reset during chunk 3 of 0x81, then 0x01
        clear_logs(0);
        pv[0] = 1'b1; pd[0] = 8'h81; ms[0] = 1'b0;
        cyc(1);
        pv[0] = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        pv[0] = 1'b1; pd[0] = 8'h01;
        cyc(1);
        pv[0] = 1'b0;
        cyc(9);
        check("reset mid transfers", 32'(tr_d[0].size()), 32'd11);
        check("reset mid data",      pack(tr_d[0], 11, 1), 32'h480);
        check("reset mid last",      pack(tr_l[0], 11, 1), 32'h001);
        check("reset mid busy",      pack(cy_b[0], 6, 1), 32'h18);
        check("reset mid valid",     pack(cy_v[0], 6, 1), 32'h39);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
